// File: rtl/siganfu_target_acquisition.sv
// -----------------------------------------------------------------------------
// siganfu_target_acquisition
//
// Radar/IFF target acquisition sequencer. Consecutive radar hits walk a track
// from SEARCH through ACQUIRE into LOCKED. Consecutive misses or a radar
// silence then drop it into LOST, and LOST holds off before searching again.
// An IFF verdict is collected while a track exists. is_enemy is only ever
// raised for a locked track with an explicit non-friendly reply.
//
// Ports
//   sysclk        in   1  clock, all logic on the rising edge
//   reboot        in   1  synchronous active-high reset
//   radar_valid   in   1  radar sample strobe
//   radar_hit     in   1  echo present (qualified by radar_valid)
//   iff_valid     in   1  IFF reply strobe
//   iff_code      in   8  IFF reply code (qualified by iff_valid)
//   target_locked out  1  registered, high exactly while LOCKED
//   is_enemy      out  1  registered, LOCKED and verdict is enemy
//   track_state   out  2  registered state: 0 SEARCH, 1 ACQUIRE, 2 LOCKED, 3 LOST
//   hit_count     out  3  registered consecutive-hit count, saturates at LOCK_HITS
//
// State    | meaning
// ---------+-------------------------------------------------------------
// SEARCH   | no track; waiting for the first hit
// ACQUIRE  | counting consecutive hits toward LOCK_HITS
// LOCKED   | track held; watching for consecutive misses or radar silence
// LOST     | track dropped; holdoff before SEARCH, a hit re-acquires
// -----------------------------------------------------------------------------
module siganfu_target_acquisition #(
    parameter int          LOCK_HITS     = 4,
    parameter int          MISS_LIMIT    = 3,
    parameter int          TIMEOUT       = 16,
    parameter int          HOLDOFF       = 8,
    parameter logic [7:0]  FRIENDLY_CODE = 8'hA5
) (
    input  logic       sysclk,
    input  logic       reboot,
    input  logic       radar_valid,
    input  logic       radar_hit,
    input  logic       iff_valid,
    input  logic [7:0] iff_code,
    output logic       target_locked,
    output logic       is_enemy,
    output logic [1:0] track_state,
    output logic [2:0] hit_count
);

    localparam int MISS_W = $clog2(MISS_LIMIT + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int HOLD_W = $clog2(HOLDOFF + 1);

    // "_LAST" values mark the count that the current cycle completes.
    localparam logic [2:0]        HIT_MAX   = 3'(LOCK_HITS);
    localparam logic [2:0]        HIT_LAST  = 3'(LOCK_HITS - 1);
    localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(MISS_LIMIT);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLDOFF);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        hit_q, hit_nxt;
    logic [MISS_W-1:0] miss_q, miss_nxt;
    logic [IDLE_W-1:0] idle_q, idle_nxt;
    logic [HOLD_W-1:0] hold_q, hold_nxt;
    logic              verdict_q, verdict_nxt;   // 1 = enemy, 0 = friendly or no reply
    logic              locked_q, enemy_q;
    logic              echo, no_echo;

    assign echo    = radar_valid &  radar_hit;
    assign no_echo = radar_valid & ~radar_hit;

    always_ff @(posedge sysclk) begin
        if (reboot) begin
            state     <= SEARCH;
            hit_q     <= '0;
            miss_q    <= '0;
            idle_q    <= '0;
            hold_q    <= '0;
            verdict_q <= 1'b0;
            locked_q  <= 1'b0;
            enemy_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            hit_q     <= hit_nxt;
            miss_q    <= miss_nxt;
            idle_q    <= idle_nxt;
            hold_q    <= hold_nxt;
            verdict_q <= verdict_nxt;
            locked_q  <= (state_nxt == LOCKED);
            enemy_q   <= (state_nxt == LOCKED) && verdict_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        hit_nxt     = hit_q;
        miss_nxt    = miss_q;
        idle_nxt    = idle_q;
        hold_nxt    = hold_q;
        verdict_nxt = verdict_q;

        case (state)
            SEARCH: begin
                if (echo) begin
                    state_nxt = ACQUIRE;
                    hit_nxt   = 3'd1;
                end
            end
            ACQUIRE: begin
                if (radar_valid) begin
                    idle_nxt = '0;
                    if (radar_hit) begin
                        if (hit_q == HIT_LAST) begin
                            state_nxt = LOCKED;
                            hit_nxt   = HIT_MAX;
                        end else if (hit_q != HIT_MAX) begin
                            hit_nxt = hit_q + 3'd1;
                        end
                    end else begin
                        state_nxt = SEARCH;
                    end
                end else if (idle_q == IDLE_LAST) begin
                    state_nxt = SEARCH;
                end else if (idle_q != IDLE_MAX) begin
                    idle_nxt = idle_q + IDLE_W'(1);
                end
            end
            LOCKED: begin
                if (radar_valid) begin
                    idle_nxt = '0;
                    if (radar_hit) begin
                        miss_nxt = '0;
                        if (hit_q != HIT_MAX) hit_nxt = hit_q + 3'd1;
                    end else begin
                        // A miss breaks the run of consecutive hits.
                        hit_nxt = '0;
                        if (miss_q == MISS_LAST) begin
                            state_nxt = LOST;
                        end else if (miss_q != MISS_MAX) begin
                            miss_nxt = miss_q + MISS_W'(1);
                        end
                    end
                end else if (idle_q == IDLE_LAST) begin
                    state_nxt = LOST;
                end else if (idle_q != IDLE_MAX) begin
                    idle_nxt = idle_q + IDLE_W'(1);
                end
            end
            LOST: begin
                if (echo) begin
                    state_nxt = ACQUIRE;
                    hit_nxt   = 3'd1;
                end else if (hold_q == HOLD_LAST) begin
                    state_nxt = SEARCH;
                end else if (hold_q != HOLD_MAX) begin
                    hold_nxt = hold_q + HOLD_W'(1);
                end
            end
            default: state_nxt = SEARCH;
        endcase

        if ((state == ACQUIRE || state == LOCKED) && iff_valid)
            verdict_nxt = (iff_code != FRIENDLY_CODE);

        // Leaving a track (or having none) drops the verdict, including any
        // IFF reply that arrived on the edge the track was dropped.
        if (state_nxt == SEARCH || state_nxt == LOST) begin
            verdict_nxt = 1'b0;
            hit_nxt     = '0;
        end

        if (state_nxt != state) begin
            idle_nxt = '0;
            miss_nxt = '0;
            hold_nxt = '0;
        end
    end

    assign track_state   = state;
    assign hit_count     = hit_q;
    assign target_locked = locked_q;
    assign is_enemy      = enemy_q;

endmodule
